// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MEM/WB stage.
// Load-op encodings, FSM state encoding, bus widths.
package mem_wb_stage_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;

  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LW  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data aligner: picks byte/half/word from a raw
// little-endian word and sign- or zero-extends it.
// Ports: i_load_op, i_addr_lo, i_word in; o_word out.
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = REG_BUS
) (
  input  logic [2:0]        i_load_op,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_word,
  output logic [DATA_W-1:0] o_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    unique case (i_addr_lo)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  // addr_lo[0] deliberately ignored for halfwords.
  assign w_half = i_addr_lo[1] ? i_word[31:16]
                               : i_word[15:0];

  always_comb begin
    o_word = i_word;
    unique case (1'b1)
      (i_load_op == LD_LB):
        o_word = {{(DATA_W-8){w_byte[7]}}, w_byte};
      (i_load_op == LD_LBU):
        o_word = {{(DATA_W-8){1'b0}}, w_byte};
      (i_load_op == LD_LH):
        o_word = {{(DATA_W-16){w_half[15]}}, w_half};
      (i_load_op == LD_LHU):
        o_word = {{(DATA_W-16){1'b0}}, w_half};
      default:
        o_word = i_word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: holds one instruction, waits for load data,
// aligns it and drives the regfile write port (also the
// forwarding source). load_pending lets ID stall.
// Ports: clk, rst (async, active-low); MEM offer
// (mem_valid/mem_ready + fields); dmem_data_ok/dmem_rdata;
// flush; wb_we/wb_waddr/wb_wdata; load_pending.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = REG_BUS,
  parameter int ADDR_W = REG_ADDR_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_is_load,
  input  logic [2:0]        mem_load_op,
  input  logic [1:0]        mem_addr_lo,
  input  logic              dmem_data_ok,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              flush,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              load_pending
);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_drop;
  logic   w_drop_nxt;

  logic              r_wreg;
  logic [ADDR_W-1:0] r_waddr;
  logic [2:0]        r_load_op;
  logic [1:0]        r_addr_lo;
  logic [DATA_W-1:0] r_wdata;

  logic              w_wait;
  logic              w_xfer;
  logic              w_ok;
  logic [2:0]        w_al_op;
  logic [1:0]        w_al_lo;
  logic [DATA_W-1:0] w_aligned;

  assign w_wait = (r_state == S_WAIT);
  assign w_xfer = mem_valid & mem_ready;
  // A return while drop is set belongs to a flushed load.
  assign w_ok   = dmem_data_ok & ~r_drop;

  // In WAIT the held load is aligned; otherwise the offer.
  assign w_al_op = w_wait ? r_load_op : mem_load_op;
  assign w_al_lo = w_wait ? r_addr_lo : mem_addr_lo;

  mem_wb_stage_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_load_op (w_al_op),
    .i_addr_lo (w_al_lo),
    .i_word    (dmem_rdata),
    .o_word    (w_aligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    w_drop_nxt  = r_drop;
    if (dmem_data_ok && r_drop)
      w_drop_nxt = 1'b0;
    unique case (r_state)
      S_WAIT: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
          // A same-cycle return is taken as the stale one.
          w_drop_nxt  = r_drop | ~dmem_data_ok;
        end else if (w_ok) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        if (w_xfer)
          w_state_nxt = (mem_is_load && !w_ok) ? S_WAIT
                                               : S_WRITE;
        else
          w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_ready    = ~w_wait & ~flush;
    load_pending = w_wait;
    wb_we        = (r_state == S_WRITE) & r_wreg &
                   (r_waddr != '0);
  end

  assign wb_waddr = r_waddr;
  assign wb_wdata = r_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wreg    <= 1'b0;
      r_waddr   <= '0;
      r_load_op <= 3'd0;
      r_addr_lo <= 2'd0;
      r_wdata   <= ZERO_WORD;
    end else if (w_xfer) begin
      r_wreg    <= mem_wreg;
      r_waddr   <= mem_waddr;
      r_load_op <= mem_load_op;
      r_addr_lo <= mem_addr_lo;
      if (!mem_is_load)
        r_wdata <= mem_wdata;
      else if (w_ok)
        r_wdata <= w_aligned;
    end else if (w_wait && !flush && w_ok) begin
      r_wdata <= w_aligned;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a tiny regfile model.
// Inputs change 1ns after posedge; outputs sampled there.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic        mem_wreg = 1'b0;
  logic [4:0]  mem_waddr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_is_load = 1'b0;
  logic [2:0]  mem_load_op = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic        dmem_data_ok = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        flush = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        load_pending;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] rf [32];

  mem_wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_wreg     (mem_wreg),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_is_load  (mem_is_load),
    .mem_load_op  (mem_load_op),
    .mem_addr_lo  (mem_addr_lo),
    .dmem_data_ok (dmem_data_ok),
    .dmem_rdata   (dmem_rdata),
    .flush        (flush),
    .wb_we        (wb_we),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= 32'hC0DE_0000 | i;
    end else if (wb_we) begin
      rf[wb_waddr] <= wb_wdata;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mem_valid    = 1'b0;
    mem_is_load  = 1'b0;
    dmem_data_ok = 1'b0;
    flush        = 1'b0;
    dmem_rdata   = 32'hDEAD_BEEF;
  endtask

  task automatic offer(input logic [4:0] rd,
                       input logic [31:0] d,
                       input logic ld,
                       input logic [2:0] op,
                       input logic [1:0] lo);
    mem_valid   = 1'b1;
    mem_wreg    = 1'b1;
    mem_waddr   = rd;
    mem_wdata   = d;
    mem_is_load = ld;
    mem_load_op = op;
    mem_addr_lo = lo;
  endtask

  task automatic do_load(input string tag,
                         input logic [2:0] op,
                         input logic [1:0] lo,
                         input logic [4:0] rd,
                         input logic [31:0] raw,
                         input int waits,
                         input logic [31:0] exp);
    offer(rd, 32'h0BAD_0BAD, 1'b1, op, lo);
    if (waits == 0) begin
      dmem_data_ok = 1'b1;
      dmem_rdata   = raw;
    end
    tick();
    clr();
    for (int i = 0; i < waits; i++) begin
      check({tag, " pend"}, 32'(load_pending), 32'd1);
      check({tag, " rdy"}, 32'(mem_ready), 32'd0);
      if (i == waits - 1) begin
        dmem_data_ok = 1'b1;
        dmem_rdata   = raw;
      end
      tick();
      clr();
    end
    check({tag, " we"}, 32'(wb_we), 32'd1);
    check({tag, " waddr"}, 32'(wb_waddr), 32'(rd));
    check({tag, " wdata"}, wb_wdata, exp);
    tick();
  endtask

  initial begin
    clr();
    #3;
    check("rst we", 32'(wb_we), 32'd0);
    check("rst waddr", 32'(wb_waddr), 32'd0);
    check("rst wdata", wb_wdata, 32'd0);
    check("rst pend", 32'(load_pending), 32'd0);
    check("rst rdy", 32'(mem_ready), 32'd1);
    #3 rst = 1'b1;
    tick();

    // Single ALU op to $5
    offer(5'd5, 32'h0000_1234, 1'b0, 3'd0, 2'd0);
    check("alu rdy", 32'(mem_ready), 32'd1);
    tick();
    clr();
    check("alu we", 32'(wb_we), 32'd1);
    check("alu waddr", 32'(wb_waddr), 32'd5);
    check("alu wdata", wb_wdata, 32'h0000_1234);
    tick();
    check("alu we off", 32'(wb_we), 32'd0);
    check("rf5", rf[5], 32'h0000_1234);

    // Loads against 0x80FF_0011
    do_load("lb3", 3'd0, 2'd3, 5'd9, 32'h80FF_0011,
            2, 32'hFFFF_FF80);
    do_load("lbu3", 3'd1, 2'd3, 5'd9, 32'h80FF_0011,
            2, 32'h0000_0080);
    do_load("lh2", 3'd2, 2'd2, 5'd9, 32'h80FF_0011,
            2, 32'hFFFF_80FF);
    do_load("lhu1", 3'd3, 2'd1, 5'd9, 32'h80FF_0011,
            1, 32'h0000_0011);
    do_load("lb2", 3'd0, 2'd2, 5'd9, 32'h80FF_0011,
            0, 32'hFFFF_FFFF);
    do_load("lbu1", 3'd1, 2'd1, 5'd9, 32'h80FF_0011,
            1, 32'h0000_0000);
    do_load("lw1", 3'd4, 2'd1, 5'd9, 32'h80FF_0011,
            3, 32'h80FF_0011);
    check("rf9", rf[9], 32'h80FF_0011);

    // Back-to-back ALU ops
    for (int i = 1; i <= 3; i++) begin
      offer(5'(i), 32'h100 + i, 1'b0, 3'd0, 2'd0);
      check($sformatf("b2b rdy%0d", i),
            32'(mem_ready), 32'd1);
      tick();
      check($sformatf("b2b we%0d", i), 32'(wb_we), 32'd1);
      check($sformatf("b2b wa%0d", i),
            32'(wb_waddr), 32'(i));
      check($sformatf("b2b wd%0d", i),
            wb_wdata, 32'h100 + i);
    end
    clr();
    tick();
    check("b2b we off", 32'(wb_we), 32'd0);
    check("rf1", rf[1], 32'h101);
    check("rf2", rf[2], 32'h102);
    check("rf3", rf[3], 32'h103);

    // Write to $0 suppressed
    offer(5'd0, 32'h0000_DEAD, 1'b0, 3'd0, 2'd0);
    tick();
    clr();
    check("r0 we", 32'(wb_we), 32'd0);
    check("r0 wdata", wb_wdata, 32'h0000_DEAD);
    tick();
    check("rf0", rf[0], 32'hC0DE_0000);

    // Flush in WAIT, stale return dropped
    offer(5'd7, 32'h0, 1'b1, 3'd4, 2'd0);
    tick();
    clr();
    check("fl pend", 32'(load_pending), 32'd1);
    flush = 1'b1;
    check("fl rdy", 32'(mem_ready), 32'd0);
    tick();
    clr();
    check("fl idle", 32'(load_pending), 32'd0);
    offer(5'd8, 32'h0, 1'b1, 3'd4, 2'd0);
    tick();
    clr();
    check("fl2 pend", 32'(load_pending), 32'd1);
    dmem_data_ok = 1'b1;
    dmem_rdata   = 32'hAAAA_AAAA;
    tick();
    clr();
    check("stale pend", 32'(load_pending), 32'd1);
    check("stale we", 32'(wb_we), 32'd0);
    dmem_data_ok = 1'b1;
    dmem_rdata   = 32'h5555_5555;
    tick();
    clr();
    check("fl2 we", 32'(wb_we), 32'd1);
    check("fl2 waddr", 32'(wb_waddr), 32'd8);
    check("fl2 wdata", wb_wdata, 32'h5555_5555);
    tick();
    check("rf8", rf[8], 32'h5555_5555);
    check("rf7", rf[7], 32'hC0DE_0007);

    // Flush and data_ok together: no drop left behind
    offer(5'd10, 32'h0, 1'b1, 3'd4, 2'd0);
    tick();
    clr();
    flush        = 1'b1;
    dmem_data_ok = 1'b1;
    dmem_rdata   = 32'h1111_1111;
    tick();
    clr();
    check("fd idle", 32'(load_pending), 32'd0);
    check("fd we", 32'(wb_we), 32'd0);
    do_load("fd lw", 3'd4, 2'd0, 5'd11, 32'h2222_2222,
            0, 32'h2222_2222);
    check("rf10", rf[10], 32'hC0DE_000A);

    // Async reset while in WAIT
    offer(5'd12, 32'h0, 1'b1, 3'd4, 2'd0);
    tick();
    clr();
    check("ar pend", 32'(load_pending), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ar we", 32'(wb_we), 32'd0);
    check("ar waddr", 32'(wb_waddr), 32'd0);
    check("ar wdata", wb_wdata, 32'd0);
    check("ar pend0", 32'(load_pending), 32'd0);
    check("ar rdy", 32'(mem_ready), 32'd1);
    #1 rst = 1'b1;
    tick();
    dmem_data_ok = 1'b1;
    dmem_rdata   = 32'h7777_7777;
    tick();
    clr();
    check("ar ign we", 32'(wb_we), 32'd0);
    check("ar ign pend", 32'(load_pending), 32'd0);
    check("ar ign wdata", wb_wdata, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Final pipeline stage between the MEM stage / data-SRAM return path and the register file write port.
- Holds one instruction and waits for load data when needed.
- Extracts and sign- or zero-extends the load byte, halfword or word, then drives the regfile's we/waddr/wdata.
- Also exports the same write as a forwarding source, plus a load-pending flag so ID can stall.

Parameters:
- DATA_W, 32: register and data width (`RegBus).
- ADDR_W, 5: register address width (`RegNumLog2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_valid  in  1  MEM offers an instruction this cycle.
- mem_ready  out  1  stage accepts the offer; transfer when mem_valid & mem_ready.
- mem_wreg  in  1  instruction writes a GPR.
- mem_waddr  in  ADDR_W  destination register.
- mem_wdata  in  DATA_W  ALU result; ignored for loads.
- mem_is_load  in  1  instruction is a load.
- mem_load_op  in  3  load type: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW.
- mem_addr_lo  in  2  byte offset of the load address.
- dmem_data_ok  in  1  load data valid on dmem_rdata this cycle.
- dmem_rdata  in  DATA_W  raw little-endian word from data SRAM.
- flush  in  1  exception/branch flush.
- wb_we  out  1  regfile write enable.
- wb_waddr  out  ADDR_W  regfile write address.
- wb_wdata  out  DATA_W  regfile write data.
- load_pending  out  1  load held awaiting data; destination is wb_waddr.

Behaviour:
- States:
  - IDLE: empty.
  - WAIT: load captured, data outstanding.
  - WRITE: result valid, writing this cycle.
- mem_ready = (state != WAIT) & ~flush.
- IDLE or WRITE, on transfer:
  - Capture wreg, waddr, load_op and addr_lo.
  - Non-load: capture mem_wdata, go to WRITE.
  - Load with a usable dmem_data_ok in the same cycle: capture the aligned data, go to WRITE.
  - Load otherwise: go to WAIT.
- IDLE or WRITE with no transfer: go to IDLE.
- WAIT:
  - On a usable dmem_data_ok: capture the aligned data, go to WRITE.
  - Otherwise stay in WAIT.
- Outputs:
  - wb_we = (state==WRITE) & wreg_q & (waddr_q != 0). Writes to $0 are suppressed.
  - wb_waddr and wb_wdata come straight from the stage registers.
  - load_pending = (state==WAIT).
- Latency:
  - Non-load accepted at edge N: wb_we high for exactly one cycle, from N to N+1; the regfile latches at edge N+1.
  - Load: the write follows 1 cycle after the usable data_ok edge.
- Back-to-back: a new instruction is accepted in WRITE, giving 1 instruction per cycle for non-loads.
- Load alignment:
  - LB/LBU: byte addr_lo, sign/zero-extended to 32.
  - LH/LHU: halfword addr_lo[1], extended to 32; addr_lo[0] is ignored.
  - LW: full word; addr_lo is ignored.
  - Misalignment is trapped upstream.
- Flush:
  - Next state is IDLE; any offer in the same cycle is not accepted.
  - A write already asserted in WRITE completes this cycle.
  - Flush in WAIT sets drop_q.
- Stale data return:
  - While drop_q=1, the next dmem_data_ok is swallowed (not usable) and clears drop_q.
  - A new load accepted while drop_q=1 waits for the following data_ok.
  - dmem_data_ok in IDLE with drop_q=0 is ignored.
- Reset (asynchronous, any state):
  - state=IDLE, drop_q=0.
  - All stage registers are 0, so wb_we=0, wb_waddr=0, wb_wdata=`ZeroWord and load_pending=0.
  - mem_ready follows its equation, so it reads 1 with flush=0.
- Simultaneous flush and data_ok in WAIT: the data is consumed as the stale return. Go to IDLE, drop_q stays 0.

Decomposition:
- Shared defines: load-op encodings (LB..LW), state encodings, and `ZeroWord/`RegBus/`RegAddrBus in defines.v.
- Sub-module load_align: purely combinational; inputs load_op, addr_lo and raw word, output the extended word. It is used on the dmem_rdata capture path.

Test Plan:
- Reset release, then offer ALU op wreg=1, waddr=5, wdata=0x1234 -> wb_we=1 for 1 cycle with waddr=5, wdata=0x1234; $5 reads 0x1234 afterwards.
- LB with addr_lo=3, dmem_rdata=0x80FF_0011 and data_ok 2 cycles later -> load_pending=1 and mem_ready=0 for 2 cycles, then write 0xFFFF_FF80. LBU on the same word -> 0x0000_0080. LH with addr_lo=2 -> 0xFFFF_80FF.
- Three back-to-back ALU ops to $1, $2, $3 -> wb_we high for 3 consecutive cycles in order; mem_ready never drops.
- Write to $0 with wdata=0xDEAD -> wb_we stays 0.
- Load to $7 in WAIT, flush, then a new LW to $8, then data_ok(0xAAAA_AAAA), then data_ok(0x5555_5555) -> the first return is dropped, $8=0x5555_5555, $7 unchanged.
- Assert rst low in WAIT -> all outputs 0 immediately. A data_ok after reset release is ignored.
